// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment capture path: segment patterns
// (active-low, {g,f,e,d,c,b,a}), capture FSM encoding and the decoded record.
package seg7_pkg;

    localparam logic [6:0] SEG7_P0    = 7'h40;
    localparam logic [6:0] SEG7_P1    = 7'h79;
    localparam logic [6:0] SEG7_P2    = 7'h24;
    localparam logic [6:0] SEG7_P3    = 7'h30;
    localparam logic [6:0] SEG7_P4    = 7'h19;
    localparam logic [6:0] SEG7_P5    = 7'h12;
    localparam logic [6:0] SEG7_P6    = 7'h02;
    localparam logic [6:0] SEG7_P7    = 7'h78;
    localparam logic [6:0] SEG7_P8    = 7'h00;
    localparam logic [6:0] SEG7_P9    = 7'h10;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    localparam int unsigned SEG7_VALUE_W = 4;
    localparam logic [SEG7_VALUE_W-1:0] SEG7_VALUE_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } seg7_state_e;

    typedef struct packed {
        logic [SEG7_VALUE_W-1:0] value;
        logic                    blank;
        logic                    err;
    } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the binary->7seg encoder: maps an active-low
// segment pattern to {value, blank, err}; anything unknown is flagged err.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0]              seg_n_i,
    output logic [SEG7_VALUE_W-1:0] value_o,
    output logic                    blank_o,
    output logic                    err_o
);

    // Table lookup; blank and err both report the out-of-range value.
    always_comb begin
        value_o = SEG7_VALUE_NONE;
        blank_o = 1'b0;
        err_o   = 1'b0;
        case (seg_n_i)
            SEG7_P0:    value_o = 4'd0;
            SEG7_P1:    value_o = 4'd1;
            SEG7_P2:    value_o = 4'd2;
            SEG7_P3:    value_o = 4'd3;
            SEG7_P4:    value_o = 4'd4;
            SEG7_P5:    value_o = 4'd5;
            SEG7_P6:    value_o = 4'd6;
            SEG7_P7:    value_o = 4'd7;
            SEG7_P8:    value_o = 4'd8;
            SEG7_P9:    value_o = 4'd9;
            SEG7_BLANK: blank_o = 1'b1;
            default:    err_o   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture_decode.sv
// Watches a multiplexed active-low 7-segment bus, waits for each digit window
// to settle, decodes it and offers one record per window on a valid/ready port.
// Optional SEG7_CAPTURE_CHANGE_ONLY_EN: push only records whose content changed.
module seg7_capture_decode
    import seg7_pkg::*;
#(
    parameter  int N_DIGITS    = 4,
    parameter  int SETTLE_CYC  = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_n,
    input  logic [N_DIGITS-1:0] dig_n,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_idx,
    output logic [3:0]          out_value,
    output logic                out_blank,
    output logic                out_err,
    output logic                overflow
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    logic [SYNC_STAGES-1:0][6:0]          seg_sync_q;
    logic [SYNC_STAGES-1:0][N_DIGITS-1:0] dig_sync_q;
    logic [6:0]          seg_s;
    logic [N_DIGITS-1:0] dig_s;
    logic                onehot_s;
    logic                changed_s;

    seg7_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_DIGITS-1:0] lat_dig_q, lat_dig_d;
    logic [6:0]          lat_seg_q, lat_seg_d;

    seg7_dec_t           dec_s;
    logic [IDX_W-1:0]    idx_s;
    logic                push_s;
    logic                load_s;
    logic                drop_s;

    logic                out_valid_q;
    logic [IDX_W-1:0]    out_idx_q;
    logic [3:0]          out_value_q;
    logic                out_blank_q;
    logic                out_err_q;
    logic                overflow_q;

    // Bus synchronizers; idle value is all-off / no digit selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sync_q <= '1;
            dig_sync_q <= '1;
        end else begin
            seg_sync_q <= {seg_sync_q[SYNC_STAGES-2:0], seg_n};
            dig_sync_q <= {dig_sync_q[SYNC_STAGES-2:0], dig_n};
        end
    end

    assign seg_s     = seg_sync_q[SYNC_STAGES-1];
    assign dig_s     = dig_sync_q[SYNC_STAGES-1];
    assign onehot_s  = $onehot(~dig_s);
    assign changed_s = (dig_s != lat_dig_q) || (seg_s != lat_seg_q);

    // FSM state, settle counter and latched window copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            lat_dig_q <= '1;
            lat_seg_q <= SEG7_BLANK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_dig_q <= lat_dig_d;
            lat_seg_q <= lat_seg_d;
        end
    end

    // Next state: cnt counts consecutive identical synchronized samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_dig_d = lat_dig_q;
        lat_seg_d = lat_seg_q;
        case (state_q)
            ST_IDLE: begin
                if (onehot_s) begin
                    lat_dig_d = dig_s;
                    lat_seg_d = seg_s;
                    cnt_d     = CNT_W'(1);
                    state_d   = (SETTLE_CYC == 1) ? ST_SAMPLE : ST_SETTLE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    lat_dig_d = dig_s;
                    lat_seg_d = seg_s;
                    cnt_d     = CNT_W'(1);
                    state_d   = onehot_s ? ST_SETTLE : ST_IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = ST_SAMPLE;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (dig_s != lat_dig_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    seg7_pattern_decode u_decode (
        .seg_n_i (lat_seg_q),
        .value_o (dec_s.value),
        .blank_o (dec_s.blank),
        .err_o   (dec_s.err)
    );

    // Position of the single selected strobe in the latched window.
    always_comb begin
        idx_s = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!lat_dig_q[i]) begin
                idx_s = IDX_W'(i);
            end else begin
                idx_s = idx_s;
            end
        end
    end

`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
    seg7_dec_t last_q [N_DIGITS];

    // Last accepted record per digit; starts as "blank" so the first real value pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                last_q[i] <= '{value: SEG7_VALUE_NONE, blank: 1'b1, err: 1'b0};
            end
        end else if (load_s) begin
            last_q[idx_s] <= dec_s;
        end
    end
`endif

    // Output control: push in SAMPLE, load if the single slot is free or draining.
    always_comb begin
        push_s = 1'b0;
        if (state_q == ST_SAMPLE) begin
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
            push_s = dec_s.err || (dec_s != last_q[idx_s]);
`else
            push_s = 1'b1;
`endif
        end else begin
            push_s = 1'b0;
        end
        load_s = push_s && (!out_valid_q || out_ready);
        drop_s = push_s && !load_s;
    end

    // Single-entry output register with sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_value_q <= 4'h0;
            out_blank_q <= 1'b0;
            out_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (load_s) begin
                out_valid_q <= 1'b1;
                out_idx_q   <= idx_s;
                out_value_q <= dec_s.value;
                out_blank_q <= dec_s.blank;
                out_err_q   <= dec_s.err;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            overflow_q <= overflow_q | drop_s;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_value = out_value_q;
    assign out_blank = out_blank_q;
    assign out_err   = out_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg7_capture_decode.sv
// Directed self-checking bench for seg7_capture_decode (default parameters);
// the change-only scenario follows SEG7_CAPTURE_CHANGE_ONLY_EN when defined.
module tb_seg7_capture_decode;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] value;
        logic       blank;
        logic       err;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_n;
    logic [3:0] dig_n;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_idx;
    logic [3:0] out_value;
    logic       out_blank;
    logic       out_err;
    logic       overflow;

    int   n_cmp  = 0;
    int   n_fail = 0;
    rec_t recs[$];

    seg7_capture_decode dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .dig_n     (dig_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_value (out_value),
        .out_blank (out_blank),
        .out_err   (out_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Log every accepted record; handshake completes at the following rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            recs.push_back({out_idx, out_value, out_blank, out_err});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic show(input int d, input logic [6:0] seg, input int cyc);
        logic [3:0] sel;
        sel = 4'b0001 << d;
        @(posedge clk);
        #1;
        dig_n = ~sel;
        seg_n = seg;
        repeat (cyc - 1) @(posedge clk);
    endtask

    task automatic idle(input int cyc);
        @(posedge clk);
        #1;
        dig_n = 4'hF;
        seg_n = 7'h7F;
        repeat (cyc - 1) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        dig_n     = 4'hF;
        seg_n     = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_idx, out_value, out_blank, out_err, overflow} !== 10'b0)
            $display("FAIL reset_outputs: got %b want %b",
                     {out_valid, out_idx, out_value, out_blank, out_err, overflow}, 10'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_latency();
        recs.delete();
        @(posedge clk);
        #1;
        dig_n = 4'b1110;
        seg_n = 7'h24;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: out_valid got %b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_idx, out_value, out_blank, out_err} !== {1'b1, 2'd0, 4'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL latency_record: got %b want %b",
                     {out_valid, out_idx, out_value, out_blank, out_err}, {1'b1, 2'd0, 4'd2, 1'b0, 1'b0});
        end
        repeat (8) @(posedge clk);
        idle(8);
        n_cmp++;
        if (recs.size() !== 1) begin
            n_fail++;
            $display("FAIL latency_count: got %0d records want 1", recs.size());
        end
    endtask

    task automatic test_scan();
        rec_t exp [4];
        exp[0] = {2'd0, 4'd1, 1'b0, 1'b0};
        exp[1] = {2'd1, 4'd9, 1'b0, 1'b0};
        exp[2] = {2'd2, 4'd7, 1'b0, 1'b0};
        exp[3] = {2'd3, 4'd0, 1'b0, 1'b0};
        recs.delete();
        show(0, 7'h79, 16);
        show(1, 7'h10, 16);
        show(2, 7'h78, 16);
        show(3, 7'h40, 16);
        idle(16);
        n_cmp++;
        if (recs.size() !== 4) begin
            n_fail++;
            $display("FAIL scan_count: got %0d records want 4", recs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (recs[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL scan_rec%0d: got %h want %h", i, recs[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_blank_err();
        recs.delete();
        show(2, 7'h7F, 16);
        show(1, 7'h55, 16);
        idle(16);
        n_cmp++;
        if (recs.size() !== 2) begin
            n_fail++;
            $display("FAIL blank_err_count: got %0d records want 2", recs.size());
        end else begin
            n_cmp++;
            if (recs[0] !== {2'd2, 4'hF, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL blank_rec: got %h want %h", recs[0], {2'd2, 4'hF, 1'b1, 1'b0});
            end
            n_cmp++;
            if (recs[1] !== {2'd1, 4'hF, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL err_rec: got %h want %h", recs[1], {2'd1, 4'hF, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_glitch();
        recs.delete();
        @(posedge clk);
        #1;
        dig_n = 4'b0111;
        seg_n = 7'h30;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(posedge clk);
            #1;
            seg_n = (i % 2 == 0) ? 7'h31 : 7'h30;
        end
        n_cmp++;
        if (recs.size() !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got %0d records valid=%b want 0 records valid=0",
                     recs.size(), out_valid);
        end
        repeat (20) @(posedge clk);
        idle(8);
        n_cmp++;
        if (recs.size() !== 1) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d records want 1", recs.size());
        end else begin
            n_cmp++;
            if (recs[0] !== {2'd3, 4'd3, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL glitch_rec: got %h want %h", recs[0], {2'd3, 4'd3, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_overflow_reset();
        recs.delete();
        out_ready = 1'b0;
        show(0, 7'h30, 16);
        show(1, 7'h19, 16);
        idle(8);
        n_cmp++;
        if ({out_valid, out_idx, out_value, out_blank, out_err} !== {1'b1, 2'd0, 4'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL held_record: got %b want %b",
                     {out_valid, out_idx, out_value, out_blank, out_err}, {1'b1, 2'd0, 4'd3, 1'b0, 1'b0});
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b want 1", overflow);
        end
        show(2, 7'h24, 6);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_idx, out_value, out_blank, out_err, overflow} !== 10'b0) begin
            n_fail++;
            $display("FAIL midsettle_reset: got %b want %b",
                     {out_valid, out_idx, out_value, out_blank, out_err, overflow}, 10'b0);
        end
        dig_n = 4'hF;
        seg_n = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(20);
        n_cmp++;
        if (recs.size() !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_quiet: got %0d records valid=%b want 0 records valid=0",
                     recs.size(), out_valid);
        end
    endtask

    task automatic test_repeat_scan();
        logic [3:0] vals [4];
        int         rounds;
        int         n_exp;
        vals[0] = 4'd1;
        vals[1] = 4'd9;
        vals[2] = 4'd7;
        vals[3] = 4'd0;
`ifdef SEG7_CAPTURE_CHANGE_ONLY_EN
        rounds = 3;
        n_exp  = 4;
`else
        rounds = 2;
        n_exp  = 8;
`endif
        recs.delete();
        for (int r = 0; r < rounds; r++) begin
            show(0, 7'h79, 16);
            show(1, 7'h10, 16);
            show(2, 7'h78, 16);
            show(3, 7'h40, 16);
        end
        idle(16);
        n_cmp++;
        if (recs.size() !== n_exp) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d records want %0d", recs.size(), n_exp);
        end else begin
            for (int i = 0; i < n_exp; i++) begin
                n_cmp++;
                if (recs[i] !== {2'(i % 4), vals[i % 4], 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL repeat_rec%0d: got %h want %h", i, recs[i],
                             {2'(i % 4), vals[i % 4], 1'b0, 1'b0});
                end
            end
        end
        recs.delete();
        show(3, 7'h12, 16);
        idle(16);
        n_cmp++;
        if (recs.size() !== 1) begin
            n_fail++;
            $display("FAIL change_count: got %0d records want 1", recs.size());
        end else begin
            n_cmp++;
            if (recs[0] !== {2'd3, 4'd5, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL change_rec: got %h want %h", recs[0], {2'd3, 4'd5, 1'b0, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_scan();
        test_blank_err();
        test_glitch();
        test_overflow_reset();
        test_repeat_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
